// File: rtl/cic_decim_output.sv
// CIC output stage: decimate by R, round-half-up shift with signed saturation,
// then buffer in a small FIFO behind a valid/ready handshake.
module cic_decim_output #(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int R          = 8,
    parameter int SHIFT      = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [IN_W-1:0]         x_in,
    input  logic                    in_en,
    output logic [OUT_W-1:0]        y_out,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic                    sat_flag,
    output logic [15:0]             drop_cnt
);

    localparam int PH_W = (R > 1) ? $clog2(R) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    // Rounding offset and saturation bounds, all at the widened IN_W+1 precision.
    localparam logic signed [IN_W:0] HALF  = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [PH_W-1:0]        phase;
    logic                   keep;
    logic                   s1_valid, s2_valid;
    logic [IN_W-1:0]        s1_data;
    logic [OUT_W-1:0]       s2_data;
    logic signed [IN_W:0]   t_sum, s_shift;
    logic                   sat_hi, sat_lo;
    logic [OUT_W-1:0]       rounded;

    logic [OUT_W-1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          count, count_nxt;
    logic                   full, pop, push, drop;
    logic [OUT_W-1:0]       head_nxt;

    assign keep = in_en && (phase == '0);

    always_comb begin
        t_sum   = $signed({s1_data[IN_W-1], s1_data}) + HALF;
        s_shift = t_sum >>> SHIFT;
        sat_hi  = s_shift > MAX_V;
        sat_lo  = s_shift < MIN_V;
        rounded = sat_hi ? MAX_V[OUT_W-1:0] :
                  sat_lo ? MIN_V[OUT_W-1:0] : s_shift[OUT_W-1:0];
    end

    assign y_valid   = (count != '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = y_valid && y_ready;
    assign push      = s2_valid && (!full || pop);
    assign drop      = s2_valid && full && !pop;
    assign count_nxt = count + CW'(push) - CW'(pop);

    // y_out is kept as a register, so compute what the head becomes after this edge.
    always_comb begin
        // NOTE: default assignment first so every path is covered and no latch is inferred.
        head_nxt = y_out;
        if (count_nxt == '0)
            head_nxt = '0;
        else if (pop)
            head_nxt = (count > CW'(1)) ? mem[AW'(rd_ptr + 1'b1)] : s2_data;
        else if (count == '0)
            head_nxt = s2_data;
    end

    // NOTE: storage is not reset; count and pointers alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= s2_data;
    end

    // NOTE: all sequential state uses non-blocking assignments to avoid ordering races.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase    <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            sat_flag <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            y_out    <= '0;
            drop_cnt <= '0;
        end else begin
            if (in_en)
                phase <= (phase == PH_W'(R - 1)) ? '0 : phase + 1'b1;

            s1_valid <= keep;
            if (keep)
                s1_data <= x_in;

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= rounded;
                if (sat_hi || sat_lo)
                    sat_flag <= 1'b1;
            end

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            y_out <= head_nxt;

            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cic_decim_output.sv
// Scoreboard bench for cic_decim_output: a reference model predicts kept samples,
// FIFO occupancy, drops and saturation; a monitor compares on every cycle.
module tb_cic_decim_output;

    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int R     = 8;
    localparam int SHIFT = 9;
    localparam int DEPTH = 4;
    localparam longint MAXO = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint MINO = -(longint'(1) << (OUT_W - 1));

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [IN_W-1:0]   x_in = '0;
    logic              in_en = 1'b0;
    logic              y_ready = 1'b0;
    logic [OUT_W-1:0]  y_out;
    logic              y_valid;
    logic              sat_flag;
    logic [15:0]       drop_cnt;

    cic_decim_output #(
        .IN_W(IN_W), .OUT_W(OUT_W), .R(R), .SHIFT(SHIFT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .x_in(x_in), .in_en(in_en),
        .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready),
        .sat_flag(sat_flag), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Round-half-up divide by 2^SHIFT with true floor, then clamp to OUT_W.
    function automatic void ref_val(input longint x, output longint q, output bit sat);
        longint v, d;
        d = longint'(1) << SHIFT;
        v = x + (d / 2);
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        sat = 1'b0;
        if (q > MAXO) begin q = MAXO; sat = 1'b1; end
        if (q < MINO) begin q = MINO; sat = 1'b1; end
    endfunction

    // Reference model state
    longint sb_q[$];
    int     en_cnt, mocc, mdrop;
    bit     msat, p1_v, p2_v, p1_sat, m_full, m_pop;
    longint p1_val, p2_val;

    always @(posedge clock) begin
        if (reset) begin
            en_cnt = 0; mocc = 0; mdrop = 0; msat = 1'b0;
            p1_v = 1'b0; p2_v = 1'b0; p1_sat = 1'b0; p1_val = 0; p2_val = 0;
            sb_q.delete();
        end else begin
            m_full = (mocc == DEPTH);
            m_pop  = (mocc > 0) && y_ready;
            if (m_pop) mocc--;
            if (p2_v) begin
                if (!m_full || m_pop) begin
                    mocc++;
                    sb_q.push_back(p2_val);
                end else if (mdrop < 65535) begin
                    mdrop++;
                end
            end
            p2_v = p1_v;
            p2_val = p1_val;
            if (p1_v && p1_sat) msat = 1'b1;
            p1_v = in_en && (en_cnt % R == 0);
            if (p1_v) ref_val(longint'($signed(x_in)), p1_val, p1_sat);
            if (in_en) en_cnt++;
        end
    end

    // Monitor: compares DUT outputs against the scoreboard mid-cycle.
    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            check("y_valid", longint'(y_valid), longint'(mocc > 0));
            if (mocc > 0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got y_out %0d expected no data at %0t",
                             $signed(y_out), $time);
                end else begin
                    check("y_out", longint'($signed(y_out)), sb_q[0]);
                    if (y_ready) void'(sb_q.pop_front());
                end
            end else begin
                check("y_out_empty", longint'($signed(y_out)), 0);
            end
            check("sat_flag", longint'(sat_flag), longint'(msat));
            check("drop_cnt", longint'(drop_cnt), longint'(mdrop));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input bit en, input logic [IN_W-1:0] x, input bit rdy);
        @(posedge clock);
        #2;
        in_en = en;
        x_in = x;
        y_ready = rdy;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clock);
        #2;
        reset = 1'b1;
        in_en = 1'b0;
        y_ready = 1'b0;
        repeat (cycles) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
    endtask

    // One kept sample followed by R-1 enabled fillers (x=0, not kept).
    task automatic kept(input logic [IN_W-1:0] x, input bit rdy);
        step(1'b1, x, rdy);
        for (int i = 1; i < R; i++) step(1'b1, '0, rdy);
    endtask

    logic [IN_W-1:0] rx;

    initial begin
        do_reset(2);
        @(negedge clock);
        check("rst_y_valid", longint'(y_valid), 0);
        check("rst_y_out", longint'($signed(y_out)), 0);
        check("rst_sat", longint'(sat_flag), 0);
        check("rst_drop", longint'(drop_cnt), 0);

        // Ramp: expect 0,8,16,...
        for (int i = 0; i < 64; i++) step(1'b1, IN_W'(i * 512), 1'b1);
        idle(6, 1'b1);

        // Rounding boundaries
        do_reset(1);
        kept(32'd256, 1'b1);
        kept(32'd255, 1'b1);
        kept(-32'sd256, 1'b1);
        kept(-32'sd257, 1'b1);
        idle(6, 1'b1);
        @(negedge clock);
        check("round_sat_clear", longint'(sat_flag), 0);

        // Saturation and stickiness
        kept(32'h7FFF_FFFF, 1'b1);
        kept(32'h8000_0000, 1'b1);
        kept(32'd1000, 1'b1);
        idle(6, 1'b1);
        @(negedge clock);
        check("sat_sticky", longint'(sat_flag), 1);

        // Back-pressure: 6 kept samples, 4 buffered, 2 dropped
        do_reset(1);
        for (int i = 0; i < 6; i++) kept(IN_W'((i + 1) * 2048), 1'b0);
        idle(4, 1'b0);
        @(negedge clock);
        check("bp_drop", longint'(drop_cnt), 2);
        check("bp_head", longint'($signed(y_out)), 4);
        idle(8, 1'b1);

        // in_en alternating
        do_reset(1);
        for (int i = 0; i < 64; i++) step(i % 2 == 0, IN_W'(i * 1000), 1'b1);
        idle(6, 1'b1);

        // Full FIFO with push and pop on the same edge: pushes at steps 2,10,18,26,34
        do_reset(1);
        for (int i = 0; i < 40; i++) step(1'b1, IN_W'(i * 700), i == 34);
        idle(4, 1'b0);
        @(negedge clock);
        check("full_pushpop_drop", longint'(drop_cnt), 0);
        idle(8, 1'b1);

        // Reset with 3 buffered samples and sat_flag set
        do_reset(1);
        for (int i = 0; i < 20; i++) step(1'b1, (i == 0) ? 32'h7FFF_FFFF : IN_W'(i * 4096), 1'b0);
        @(negedge clock);
        check("pre_rst_sat", longint'(sat_flag), 1);
        do_reset(1);
        @(negedge clock);
        check("mid_rst_valid", longint'(y_valid), 0);
        check("mid_rst_y_out", longint'($signed(y_out)), 0);
        check("mid_rst_sat", longint'(sat_flag), 0);
        check("mid_rst_drop", longint'(drop_cnt), 0);
        step(1'b1, 32'd1024, 1'b1);
        idle(5, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset(1);
            case ($urandom_range(0, 2))
                0: rx = $urandom;
                1: rx = IN_W'($signed($urandom_range(0, 33554431)) - 16777216);
                default: rx = IN_W'(($signed($urandom_range(0, 2000)) - 1000) * 512 + 256
                                    + $signed($urandom_range(0, 2)) - 1);
            endcase
            step($urandom_range(0, 3) != 0, rx, $urandom_range(0, 2) != 0);
        end

        idle(20, 1'b1);
        @(negedge clock);
        check("drain_empty", longint'(y_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
